// File: rtl/odo_pkg.sv
// Shared definitions for the odometer beat-period measurement block:
// FSM state encoding, default widths and ROSC pair indices.
package odo_pkg;

  // Measurement controller states
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WARMUP = 3'd1,
    ARM    = 3'd2,
    COUNT  = 3'd3,
    DONE   = 3'd4
  } odo_meas_state_t;

  // Default widths and timing
  localparam int ODO_CNT_W      = 24;
  localparam int ODO_NB_W       = 8;
  localparam int ODO_SEL_W      = 2;
  localparam int ODO_WARMUP_CYC = 256;

  // Stacked REF/STRESS oscillator pairs behind ROSC_EN
  localparam int ODO_NUM_PAIRS  = 4;
  localparam int ODO_ROSC_PAIR0 = 0;
  localparam int ODO_ROSC_PAIR1 = 1;
  localparam int ODO_ROSC_PAIR2 = 2;
  localparam int ODO_ROSC_PAIR3 = 3;

endpackage

// File: rtl/odo_sync_edge.sv
// Two-flop synchroniser for the asynchronous beat signal followed by an
// edge-detect flop; rise is a one-cycle pulse per synchronised rising edge.
module odo_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic s1_q, s2_q, s3_q;
  logic s1_d, s2_d, s3_d;

  // Next values of the shift chain: s1/s2 synchronise, s3 delays for edge detect
  always_comb begin
    s1_d = d;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  // Synchroniser and edge flops, cleared by the asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign rise = s2_q & ~s3_q;

endmodule

// File: rtl/odo_beat_period_meas.sv
// Beat-period measurement controller for the stacked odometer ring
// oscillators. Enables one REF/STRESS pair, lets it settle, then counts the
// CLK cycles spanning NUM_BEATS rising-to-rising beat periods and hands the
// total to the consumer with a valid/ack handshake.
module odo_beat_period_meas
  import odo_pkg::*;
#(
  parameter int CNT_W      = ODO_CNT_W,
  parameter int WARMUP_CYC = ODO_WARMUP_CYC,
  parameter int NB_W       = ODO_NB_W,
  parameter int SEL_W      = ODO_SEL_W
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic             ABORT,
  input  logic [SEL_W-1:0] ROSC_SEL,
  input  logic [NB_W-1:0]  NUM_BEATS,
  input  logic             BEAT_IN,
  input  logic             RESULT_ACK,
  output logic [3:0]       ROSC_EN,
  output logic             BUSY,
  output logic [CNT_W-1:0] RESULT,
  output logic             RESULT_VALID,
  output logic             OVERFLOW
);

  // Warm-up counter sized to hold WARMUP_CYC-1
  localparam int WAIT_W = (WARMUP_CYC > 1) ? $clog2(WARMUP_CYC) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(WARMUP_CYC - 1);

  odo_meas_state_t   state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [NB_W-1:0]   nb_q, nb_d;
  logic [NB_W-1:0]   beats_left_q, beats_left_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  result_q, result_d;
  logic              ovf_q, ovf_d;

  logic              beat_rise;
  logic              cnt_sat;
  logic [CNT_W-1:0]  cnt_inc;
  logic              rosc_on;

  odo_sync_edge u_beat_sync (
    .clk  (CLK),
    .rst  (RESET),
    .d    (BEAT_IN),
    .rise (beat_rise)
  );

  // Saturating increment; also forms the final result (cnt+1) so that an
  // all-ones counter reports all-ones rather than wrapping to zero.
  assign cnt_sat = &cnt_q;
  assign cnt_inc = cnt_sat ? cnt_q : (cnt_q + CNT_W'(1));

  // Next-state and datapath updates; ABORT overrides everything else
  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    sel_d        = sel_q;
    nb_d         = nb_q;
    beats_left_d = beats_left_q;
    cnt_d        = cnt_q;
    result_d     = result_q;
    ovf_d        = ovf_q;

    if (ABORT) begin
      // Also covers START+ABORT in IDLE: nothing is captured, stay put.
      // RESULT/OVERFLOW keep their previous values.
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (START) begin
            state_d = WARMUP;
            wait_d  = WAIT_LOAD;
            sel_d   = ROSC_SEL;
            // A request for zero beats is measured as a single beat
            nb_d    = (NUM_BEATS == '0) ? NB_W'(1) : NUM_BEATS;
          end
        end

        WARMUP: begin
          // Oscillators settle; beat edges seen here are meaningless
          if (wait_q == '0) begin
            state_d = ARM;
          end else begin
            wait_d = wait_q - WAIT_W'(1);
          end
        end

        ARM: begin
          // First rising beat edge opens the measurement window
          if (beat_rise) begin
            cnt_d        = '0;
            beats_left_d = nb_q;
            state_d      = COUNT;
          end
        end

        COUNT: begin
          cnt_d = cnt_inc;
          if (beat_rise) begin
            if (beats_left_q == NB_W'(1)) begin
              // cnt_q holds cycles since the opening edge minus one
              result_d = cnt_inc;
              ovf_d    = cnt_sat;
              state_d  = DONE;
            end else begin
              beats_left_d = beats_left_q - NB_W'(1);
            end
          end
        end

        DONE: begin
          if (RESULT_ACK) begin
            state_d = IDLE;
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous clear
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= IDLE;
      wait_q       <= '0;
      sel_q        <= '0;
      nb_q         <= '0;
      beats_left_q <= '0;
      cnt_q        <= '0;
      result_q     <= '0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      sel_q        <= sel_d;
      nb_q         <= nb_d;
      beats_left_q <= beats_left_d;
      cnt_q        <= cnt_d;
      result_q     <= result_d;
      ovf_q        <= ovf_d;
    end
  end

  // Oscillators run from WARMUP through COUNT; the decode works straight off
  // the state register so an asynchronous reset drops ROSC_EN immediately.
  assign rosc_on = (state_q == WARMUP) || (state_q == ARM) || (state_q == COUNT);

  generate
    for (genvar gi = 0; gi < ODO_NUM_PAIRS; gi++) begin : g_rosc_en
      assign ROSC_EN[gi] = rosc_on && (int'(sel_q) == gi);
    end
  endgenerate

  assign BUSY         = (state_q != IDLE);
  assign RESULT_VALID = (state_q == DONE);
  assign RESULT       = result_q;
  assign OVERFLOW     = ovf_q;

endmodule
